uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmit line between NUM_REQ requesters.
- Also sequences the frame (start, data LSB-first, stop) on baud ticks from the existing divider's `en` output.
- Sits between the command/telemetry sources and the board TX pin.
- One frame in flight at a time; grants are fair across requesters.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: data bits per frame.
- STOP_BITS, 1: stop bits per frame (1 or 2).
- ID_W, 3: width of the granted-requester index; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-high reset.
- baud_en, input, 1: one-cycle baud tick from the divider; sampled on posedge clk.
- req, input, NUM_REQ: per-requester transmit request, level; held until the matching gnt.
- data, input, NUM_REQ*DATA_W: flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt, output, NUM_REQ: one-hot, single-cycle pulse; marks the cycle that requester's data is captured.
- cur_id, output, ID_W: index of the requester currently being sent; valid while busy.
- busy, output, 1: high from the grant cycle until the end of the last stop bit.
- tx, output, 1: serial line; idles high.
- done, output, 1: one-cycle pulse when the frame completes.

Behaviour:
- Reset (async, any time including mid-frame):
  - tx=1, gnt=0, busy=0, done=0, cur_id=0.
  - State IDLE, round-robin pointer=0, bit counter=0, shift register=0.
  - A partial frame is abandoned; no done pulse.
- States: IDLE, SYNC, START, DATA, STOP.
- IDLE:
  - If req!=0, select the first set bit at or above the pointer, wrapping around.
  - Assert gnt[sel] for exactly this one cycle.
  - Latch data slice into the shift register and sel into cur_id.
  - busy<=1, go to SYNC. Arbitration does not wait for baud_en.
  - If req==0, stay in IDLE; baud_en is ignored.
- SYNC: on baud_en, tx<=0, go to START. Aligns the start bit to a full baud period.
- START: on baud_en, tx<=shift[0], shift>>=1, bitcnt<=0, go to DATA.
- DATA: on baud_en:
  - If bitcnt==DATA_W-1: tx<=1, stopcnt<=0, go to STOP.
  - Else: tx<=shift[0], shift>>=1, bitcnt++.
- STOP: on baud_en:
  - If stopcnt==STOP_BITS-1: done<=1, busy<=0, pointer<=(cur_id+1) mod NUM_REQ, go to IDLE.
  - Else: stopcnt++, tx stays 1.
- Outside baud_en, every state holds and tx is unchanged.
- Each line bit lasts exactly one baud period (tick to tick).
- Frame length: 1+DATA_W+STOP_BITS periods after the SYNC tick.
- Back-to-back:
  - A new grant may occur in the cycle immediately after done.
  - The next start bit begins on the next baud_en after that grant.
  - No extra idle period is added beyond that SYNC wait.
- Pointer update: only on frame completion; requesters below the pointer wait one rotation.
- Request withdrawal: req dropping before its grant is legal and is simply not served.
- Request changes while busy are ignored until IDLE.
- Simultaneous events:
  - baud_en in the grant cycle is ignored, since SYNC has not yet been entered.
  - rst overrides everything.
- Width rule: the pointer wraps to 0 when cur_id+1 equals NUM_REQ, with no out-of-range index.
- done and gnt are never high in the same cycle.

Test Plan:
- Single requester: NUM_REQ=4, baud_en every 4 clk, req[0]=1, data slice 0 = 0xA5.
  - gnt=4'b0001 for 1 cycle.
  - tx after the SYNC tick: 0,1,0,1,0,0,1,0,1,1, each held exactly 4 clk.
  - done pulses once, then tx stays 1.
- Round robin: req=4'b1111 held, re-asserted after each gnt.
  - Grant order 0,1,2,3,0; cur_id matches each frame.
  - Exactly one gnt per done.
- Fairness skip: pointer=2 (after serving 1), req=4'b0011 -> next grant is requester 0, then 1.
- Reset mid-frame: assert rst during DATA bit 3.
  - tx=1, busy=0, done=0 immediately, without waiting for a clk edge.
  - After release with req[2]=1: a full new frame; the first grant goes to requester 2.
- STOP_BITS=2, data 0x00: tx shows 0 for 9 periods, then 1 for 2 periods; done only after the second stop period.
- Idle ticks: baud_en toggling with req=0 for 100 cycles -> tx=1, busy=0, gnt=0, done=0 throughout.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler: arbitrates NUM_REQ sources
// onto one serial line and frames each byte on divider baud ticks.
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int ID_W      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      baud_en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ID_W-1:0]           cur_id,
  output logic                      busy,
  output logic                      tx,
  output logic                      done
);

  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [CW-1:0]       bitcnt;
  logic [1:0]          stopcnt;
  logic [DATA_W-1:0]   shift;

  logic [ID_W-1:0]     sel;
  logic [NUM_REQ-1:0]  onehot;
  logic [DATA_W-1:0]   slice;
  logic [ID_W-1:0]     nxt_ptr;
  logic                hit;
  int                  idx;

  // first requester at or above ptr, wrapping around
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = ID_W'(idx);
      end
    end
  end

  assign onehot  = NUM_REQ'(1) << sel;
  assign slice   = data[int'(sel)*DATA_W +: DATA_W];
  assign nxt_ptr = (cur_id == ID_W'(NUM_REQ-1))
                 ? '0 : cur_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      bitcnt  <= '0;
      stopcnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cur_id  <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt    <= onehot;
            shift  <= slice;
            cur_id <= sel;
            busy   <= 1'b1;
            state  <= SYNC;
          end
        end
        SYNC: begin
          if (baud_en) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_en) begin
            tx     <= shift[0];
            shift  <= shift >> 1;
            bitcnt <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (baud_en) begin
            if (bitcnt == CW'(DATA_W-1)) begin
              tx      <= 1'b1;
              stopcnt <= '0;
              state   <= STOP;
            end else begin
              tx     <= shift[0];
              shift  <= shift >> 1;
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (baud_en) begin
            if (stopcnt == 2'(STOP_BITS-1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              ptr   <= nxt_ptr;
              state <= IDLE;
            end else begin
              stopcnt <= stopcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: one-stop-bit and
// two-stop-bit instances, baud tick every 4 clocks.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        baud_en = 1'b0;
  logic [3:0]  req0 = '0, req1 = '0;
  logic [31:0] data0 = '0, data1 = '0;
  logic [3:0]  gnt0, gnt1;
  logic [2:0]  id0, id1;
  logic        busy0, busy1, tx0, tx1, done0, done1;

  uart_tx_sched #(.NUM_REQ(4), .DATA_W(8),
    .STOP_BITS(1), .ID_W(3)) u0 (
    .clk(clk), .rst(rst), .baud_en(baud_en),
    .req(req0), .data(data0), .gnt(gnt0),
    .cur_id(id0), .busy(busy0), .tx(tx0),
    .done(done0));

  uart_tx_sched #(.NUM_REQ(4), .DATA_W(8),
    .STOP_BITS(2), .ID_W(3)) u1 (
    .clk(clk), .rst(rst), .baud_en(baud_en),
    .req(req1), .data(data1), .gnt(gnt1),
    .cur_id(id1), .busy(busy1), .tx(tx1),
    .done(done1));

  always #5 clk = ~clk;

  int bcnt = 0;
  initial forever begin
    @(negedge clk);
    bcnt = (bcnt + 1) % 4;
    baud_en = (bcnt == 0);
  end

  typedef struct {
    int         unit;
    int         id;
    logic [7:0] d;
  } exp_t;

  exp_t sbq[$];
  int compared = 0;
  int mismatched = 0;

  function automatic void chk(string nm, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endfunction

  bit          coll[2];
  int          nb[2];
  logic [15:0] bits[2];
  exp_t        cur[2];
  bit          glitch[2];
  logic        ptx[2];
  int          frames[2];

  // monitor: decodes each frame tick by tick, checks on gnt/done
  always @(posedge clk) begin
    logic [3:0]  gv;
    logic [2:0]  idv;
    logic        txv, dv, be;
    logic [15:0] exv;
    int          sb;
    be = baud_en;
    #1;
    for (int u = 0; u < 2; u++) begin
      gv  = (u == 1) ? gnt1 : gnt0;
      idv = (u == 1) ? id1 : id0;
      txv = (u == 1) ? tx1 : tx0;
      dv  = (u == 1) ? done1 : done0;
      sb  = (u == 1) ? 2 : 1;
      if (rst) begin
        coll[u] = 1'b0;
      end else begin
        if (coll[u] && !be && txv != ptx[u])
          glitch[u] = 1'b1;
        if (dv) begin
          if (!coll[u] || !be) begin
            chk("done_spurious", 1, 0);
          end else begin
            exv = '0;
            exv[8:1] = cur[u].d;
            for (int k = 0; k < sb; k++)
              exv[9+k] = 1'b1;
            chk("frame_len", nb[u], 9 + sb);
            chk("frame_bits", int'(bits[u]), int'(exv));
            chk("bit_hold", int'(glitch[u]), 0);
            frames[u]++;
          end
          coll[u] = 1'b0;
        end else if (coll[u] && be) begin
          if (nb[u] < 16)
            bits[u][nb[u]] = txv;
          nb[u]++;
        end
        if (gv != 0) begin
          if (coll[u] || dv)
            chk("gnt_overlap", 1, 0);
          if (sbq.size() == 0) begin
            chk("gnt_unexpected", int'(gv), 0);
          end else begin
            cur[u] = sbq.pop_front();
            chk("gnt_unit", u, cur[u].unit);
            chk("gnt_onehot", int'(gv), 1 << cur[u].id);
            chk("cur_id", int'(idv), cur[u].id);
            coll[u]   = 1'b1;
            nb[u]     = 0;
            bits[u]   = '0;
            glitch[u] = 1'b0;
          end
        end
      end
      ptx[u] = txv;
    end
  end

  task automatic wait_gnt(input int u);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (((u == 1) ? gnt1 : gnt0) != 0)
        ok = 1'b1;
    end
    if (!ok) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done(input int u);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (((u == 1) ? done1 : done0) != 0)
        ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ticks;
    bit bad;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", int'(tx0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_gnt", int'(gnt0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_id", int'(id0), 0);
    @(negedge clk);
    rst = 1'b0;

    // single requester, 0xA5
    data0[7:0] = 8'hA5;
    sbq.push_back('{0, 0, 8'hA5});
    req0 = 4'b0001;
    wait_gnt(0);
    req0 = '0;
    wait_done(0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
    end
    chk("post_done_idle", int'(bad), 0);

    // round robin with all requests held
    do_reset();
    data0 = 32'h44332211;
    sbq.push_back('{0, 0, 8'h11});
    sbq.push_back('{0, 1, 8'h22});
    sbq.push_back('{0, 2, 8'h33});
    sbq.push_back('{0, 3, 8'h44});
    sbq.push_back('{0, 0, 8'h11});
    req0 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(0);
      if (k == 4) req0 = '0;
    end
    wait_done(0);

    // fairness: serve 1, then 0 and 1 pending
    do_reset();
    data0 = 32'h00005AC7;
    sbq.push_back('{0, 1, 8'h5A});
    req0 = 4'b0010;
    wait_gnt(0);
    req0 = '0;
    wait_done(0);
    sbq.push_back('{0, 0, 8'hC7});
    sbq.push_back('{0, 1, 8'h5A});
    req0 = 4'b0011;
    wait_gnt(0);
    req0[0] = 1'b0;
    wait_gnt(0);
    req0 = '0;
    wait_done(0);

    // reset while data bit 3 (a 0) is on the line
    do_reset();
    data0 = 32'h00000035;
    sbq.push_back('{0, 0, 8'h35});
    req0 = 4'b0001;
    wait_gnt(0);
    req0 = '0;
    ticks = 0;
    for (int i = 0; i < 100 && ticks < 5; i++) begin
      @(posedge clk);
      if (baud_en) ticks++;
    end
    @(negedge clk);
    chk("mid_tx_bit3", int'(tx0), 0);
    chk("mid_busy", int'(busy0), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_tx", int'(tx0), 1);
    chk("async_busy", int'(busy0), 0);
    chk("async_done", int'(done0), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    data0 = 32'h00C30000;
    sbq.push_back('{0, 2, 8'hC3});
    req0 = 4'b0100;
    wait_gnt(0);
    req0 = '0;
    wait_done(0);

    // two stop bits, all-zero payload
    data1[7:0] = 8'h00;
    sbq.push_back('{1, 0, 8'h00});
    req1 = 4'b0001;
    wait_gnt(1);
    req1 = '0;
    wait_done(1);

    // idle ticks with no requests
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 ||
          gnt0 !== '0 || done0 !== 1'b0)
        bad = 1'b1;
      if (tx1 !== 1'b1 || busy1 !== 1'b0 ||
          gnt1 !== '0 || done1 !== 1'b0)
        bad = 1'b1;
    end
    chk("idle_quiet", int'(bad), 0);

    repeat (4) @(negedge clk);
    chk("frames_u0", frames[0], 10);
    chk("frames_u1", frames[1], 1);
    chk("sbq_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      compared, mismatched);
    $finish;
  end

endmodule
